// File: rtl/clk_mon_pkg.sv
// Shared types and constants for the clock-domain monitors.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous level onto clk_i and flags its rising edges.
module sync_edge_detect
  import clk_mon_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   dly_q;
  logic                   dly_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/clock_ratio_monitor.sv
// Measures mon_clk period and high time in clk_in cycles and tracks ratio lock.
module clock_ratio_monitor
  import clk_mon_pkg::*;
#(
  parameter int EXPECTED_DIV = 4,
  parameter int TOL          = 0,
  parameter int LOCK_COUNT   = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             enable,
  input  logic             mon_clk,
  output logic [CNT_W-1:0] period_count,
  output logic [CNT_W-1:0] high_count,
  output logic             period_valid,
  output logic             locked,
  output logic             mismatch,
  output logic             timeout
);

  localparam int                 MATCH_W   = $clog2(LOCK_COUNT + 1);
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

  // One extra bit keeps the absolute difference from wrapping.
  function automatic logic in_tol(input logic [CNT_W-1:0] period);
    logic [CNT_W:0] p;
    logic [CNT_W:0] e;
    logic [CNT_W:0] diff;
    p    = {1'b0, period};
    e    = (CNT_W+1)'(EXPECTED_DIV);
    diff = (p >= e) ? (p - e) : (e - p);
    return diff <= (CNT_W+1)'(TOL);
  endfunction

  function automatic logic [MATCH_W-1:0] sat_inc(input logic [MATCH_W-1:0] v);
    return (v == MATCH_MAX) ? v : v + 1'b1;
  endfunction

  logic sync;
  logic rise;

  sync_edge_detect u_sync (
    .clk_i  (clk_in),
    .rst_i  (rst),
    .async_i(mon_clk),
    .sync_o (sync),
    .rise_o (rise)
  );

  state_t             state_q,    state_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [CNT_W-1:0]   high_q,     high_d;
  logic [MATCH_W-1:0] match_q,    match_d;
  logic [MATCH_W-1:0] match_inc;
  logic               locked_q,   locked_d;
  logic [CNT_W-1:0]   period_q,   period_d;
  logic [CNT_W-1:0]   high_out_q, high_out_d;
  logic               pv_q,       pv_d;
  logic               mm_q,       mm_d;
  logic               to_q,       to_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    high_d     = high_q;
    match_d    = match_q;
    locked_d   = locked_q;
    period_d   = period_q;
    high_out_d = high_out_q;
    pv_d       = 1'b0;
    mm_d       = 1'b0;
    to_d       = 1'b0;
    match_inc  = sat_inc(match_q);

    // Dropping enable overrides everything, including a coincident rise.
    if (!enable) begin
      state_d  = IDLE;
      cnt_d    = '0;
      high_d   = '0;
      match_d  = '0;
      locked_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ARM;
        end
        ARM: begin
          if (rise) begin
            state_d = MEASURE;
            cnt_d   = CNT_ONE;
            high_d  = CNT_ONE;
          end
        end
        MEASURE: begin
          // A rise on the saturation cycle still reports a full-scale period.
          if (rise) begin
            period_d   = cnt_q;
            high_out_d = high_q;
            pv_d       = 1'b1;
            cnt_d      = CNT_ONE;
            high_d     = CNT_ONE;
            if (in_tol(cnt_q)) begin
              match_d  = match_inc;
              locked_d = locked_q | (match_inc == MATCH_MAX);
            end else begin
              mm_d     = 1'b1;
              match_d  = '0;
              locked_d = 1'b0;
            end
          end else if (cnt_q == CNT_MAX) begin
            to_d     = 1'b1;
            locked_d = 1'b0;
            match_d  = '0;
            cnt_d    = '0;
            high_d   = '0;
            state_d  = ARM;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            high_d = high_q + CNT_W'(sync);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      high_q     <= '0;
      match_q    <= '0;
      locked_q   <= 1'b0;
      period_q   <= '0;
      high_out_q <= '0;
      pv_q       <= 1'b0;
      mm_q       <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      high_q     <= high_d;
      match_q    <= match_d;
      locked_q   <= locked_d;
      period_q   <= period_d;
      high_out_q <= high_out_d;
      pv_q       <= pv_d;
      mm_q       <= mm_d;
      to_q       <= to_d;
    end
  end

  assign period_count = period_q;
  assign high_count   = high_out_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign mismatch     = mm_q;
  assign timeout      = to_q;

endmodule

// File: tb/tb_clock_ratio_monitor.sv
// Randomized bench for clock_ratio_monitor with an edge-timestamp reference model.
module tb_clock_ratio_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic mon_clk = 1'b0;

  logic [5:0] pc0, hc0;
  logic       pv0, lk0, mm0, to0;
  logic [7:0] pc1, hc1;
  logic       pv1, lk1, mm1, to1;

  always #5 clk = ~clk;

  clock_ratio_monitor #(.EXPECTED_DIV(4), .TOL(0), .LOCK_COUNT(4), .CNT_W(6)) u0 (
    .clk_in(clk), .rst(rst), .enable(enable), .mon_clk(mon_clk),
    .period_count(pc0), .high_count(hc0), .period_valid(pv0),
    .locked(lk0), .mismatch(mm0), .timeout(to0)
  );

  clock_ratio_monitor #(.EXPECTED_DIV(6), .TOL(2), .LOCK_COUNT(3), .CNT_W(8)) u1 (
    .clk_in(clk), .rst(rst), .enable(enable), .mon_clk(mon_clk),
    .period_count(pc1), .high_count(hc1), .period_valid(pv1),
    .locked(lk1), .mismatch(mm1), .timeout(to1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: per-instance parameters and behavioural state.
  int P_EXP [2] = '{4, 6};
  int P_TOL [2] = '{0, 2};
  int P_LC  [2] = '{4, 3};
  int P_MAX [2] = '{63, 255};

  int cyc = 0;
  bit mdl_ok = 0;
  bit hist [3];          // hist[k]: mon_clk as sampled k+1 edges ago
  bit m_act [2];         // out of IDLE
  bit m_arm [2];         // a reference rise has been seen
  int m_last [2];        // cycle of the last accepted rise
  int m_hacc [2];        // synced-high cycles since that rise
  int m_match [2];
  bit m_lock [2];
  int m_pc [2];
  int m_hc [2];
  bit m_pv [2];
  bit m_mm [2];
  bit m_to [2];

  task automatic model_step();
    bit s, rise;
    int per, d;
    cyc++;
    if (rst) begin
      mdl_ok = 1;
      for (int k = 0; k < 3; k++) hist[k] = 0;
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 0; m_arm[i] = 0; m_last[i] = 0; m_hacc[i] = 0;
        m_match[i] = 0; m_lock[i] = 0; m_pc[i] = 0; m_hc[i] = 0;
        m_pv[i] = 0; m_mm[i] = 0; m_to[i] = 0;
      end
    end else begin
      s    = hist[1];
      rise = hist[1] && !hist[2];
      for (int i = 0; i < 2; i++) begin
        m_pv[i] = 0; m_mm[i] = 0; m_to[i] = 0;
        if (!enable) begin
          m_act[i] = 0; m_arm[i] = 0; m_match[i] = 0; m_lock[i] = 0;
        end else if (!m_act[i]) begin
          m_act[i] = 1;
        end else if (!m_arm[i]) begin
          if (rise) begin
            m_arm[i] = 1; m_last[i] = cyc; m_hacc[i] = 1;
          end
        end else if (rise) begin
          per = cyc - m_last[i];
          m_pc[i] = per;
          m_hc[i] = m_hacc[i];
          m_pv[i] = 1;
          d = (per >= P_EXP[i]) ? per - P_EXP[i] : P_EXP[i] - per;
          if (d <= P_TOL[i]) begin
            if (m_match[i] < P_LC[i]) m_match[i]++;
            if (m_match[i] == P_LC[i]) m_lock[i] = 1;
          end else begin
            m_mm[i] = 1; m_match[i] = 0; m_lock[i] = 0;
          end
          m_last[i] = cyc;
          m_hacc[i] = 1;
        end else if (cyc - m_last[i] == P_MAX[i]) begin
          m_to[i] = 1; m_lock[i] = 0; m_match[i] = 0; m_arm[i] = 0;
        end else begin
          m_hacc[i] += int'(s);
        end
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = mon_clk;
    end
  endtask

  task automatic cmp(input int i, input int pc, input int hc,
                     input logic pv, input logic lk, input logic mm, input logic to);
    chk($sformatf("u%0d.period_count", i), pc, m_pc[i]);
    chk($sformatf("u%0d.high_count", i), hc, m_hc[i]);
    chk($sformatf("u%0d.period_valid", i), int'(pv), int'(m_pv[i]));
    chk($sformatf("u%0d.locked", i), int'(lk), int'(m_lock[i]));
    chk($sformatf("u%0d.mismatch", i), int'(mm), int'(m_mm[i]));
    chk($sformatf("u%0d.timeout", i), int'(to), int'(m_to[i]));
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (mdl_ok) begin
      cmp(0, int'(pc0), int'(hc0), pv0, lk0, mm0, to0);
      cmp(1, int'(pc1), int'(hc1), pv1, lk1, mm1, to1);
    end
  end

  // Hand-computed expectations for the directed phases.
  int lit_phase = 0;
  int lit_n = 0;
  int last_pv_cyc = 0;
  int to_n = 0;

  initial forever begin
    @(negedge clk);
    case (lit_phase)
      1: begin
        chk("p1_mismatch", int'(mm0), 0);
        if (pv0) begin
          lit_n++;
          chk("p1_period", int'(pc0), 4);
          chk("p1_high", int'(hc0), 2);
          chk("p1_locked", int'(lk0), int'(lit_n >= 4));
        end
      end
      2: begin
        if (to0) begin
          to_n++;
          chk("to_delay", cyc - last_pv_cyc, 63);
          chk("to_locked", int'(lk0), 0);
        end
      end
      3: begin
        if (pv0) begin
          lit_n++;
          chk("p3_period", int'(pc0), 8);
          chk("p3_high", int'(hc0), 4);
          chk("p3_mismatch", int'(mm0), 1);
          chk("p3_locked", int'(lk0), 0);
        end
      end
      5: begin
        if (pv0) begin
          lit_n++;
          chk("rst_period", int'(pc0), 4);
          chk("rst_high", int'(hc0), 2);
        end
      end
      6: begin
        chk("sat_timeout", int'(to0), 0);
        if (pv0) begin
          lit_n++;
          chk("sat_period", int'(pc0), 63);
          chk("sat_high", int'(hc0), 20);
        end
      end
      default: ;
    endcase
    if (pv0) last_pv_cyc = cyc;
  end

  task automatic tick(input logic v);
    @(posedge clk);
    #1 mon_clk = v;
  endtask

  task automatic run_div(input int n, input int h, input int periods);
    for (int p = 0; p < periods; p++)
      for (int ph = 0; ph < n; ph++) tick(ph < h);
  endtask

  int mode, n, h, k;

  initial begin
    repeat (2) tick(1'b0);
    #0 rst = 1'b0;
    enable = 1'b1;
    chk("reset_period", int'(pc0), 0);
    chk("reset_locked", int'(lk0), 0);
    chk("reset_valid", int'(pv0), 0);

    // Matching ratio: lock after four reports.
    lit_n = 0; lit_phase = 1;
    run_div(4, 2, 10);
    chk("p1_reports", int'(lit_n >= 7), 1);

    // mon_clk stalls low: one timeout on the narrow instance.
    lit_phase = 2;
    repeat (80) tick(1'b0);
    chk("to_once", to_n, 1);

    // Ratio 8 against expected 4.
    lit_n = 0; lit_phase = 3;
    run_div(8, 4, 6);
    chk("p3_reports", int'(lit_n >= 4), 1);
    lit_phase = 0;

    // Relock at 4, then drop enable on the internal rise cycle.
    run_div(4, 2, 8);
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);
    chk("en_pre_locked", int'(lk0), 1);
    enable = 1'b0;
    tick(1'b0);
    chk("en_valid", int'(pv0), 0);
    chk("en_locked", int'(lk0), 0);
    chk("en_hold_period", int'(pc0), 4);
    repeat (3) tick(1'b0);
    enable = 1'b1;
    repeat (3) tick(1'b0);

    // Period equal to the counter ceiling: rise beats saturation.
    lit_n = 0; lit_phase = 6;
    run_div(63, 20, 3);
    chk("sat_reports", int'(lit_n >= 1), 1);
    lit_phase = 0;

    // Reset mid-period.
    run_div(4, 2, 5);
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    rst = 1'b1;
    tick(1'b1);
    rst = 1'b0;
    chk("rst_pc", int'(pc0), 0);
    chk("rst_hc", int'(hc0), 0);
    chk("rst_pv", int'(pv0), 0);
    chk("rst_lk", int'(lk0), 0);
    chk("rst_mm", int'(mm0), 0);
    chk("rst_to", int'(to0), 0);
    lit_n = 0; lit_phase = 5;
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    run_div(4, 2, 6);
    chk("rst_reports", int'(lit_n >= 4), 1);
    lit_phase = 0;

    // Randomized segments.
    for (int seg = 0; seg < 40; seg++) begin
      mode = $urandom_range(0, 9);
      case (mode)
        0: begin
          @(posedge clk); #1 rst = 1'b1;
          @(posedge clk); #1 rst = 1'b0;
        end
        1: begin
          k = $urandom_range(1, 6);
          @(posedge clk); #1 enable = 1'b0;
          repeat (k) tick(1'($urandom_range(0, 1)));
          enable = 1'b1;
        end
        2: repeat (24) tick(1'($urandom_range(0, 1)));
        3: repeat (70) tick(1'b0);
        4, 5: begin
          n = $urandom_range(2, 12);
          h = $urandom_range(1, n - 1);
          run_div(n, h, $urandom_range(2, 6));
        end
        default: begin
          n = ($urandom_range(0, 1) == 1) ? 4 : 6;
          h = $urandom_range(1, n - 1);
          run_div(n, h, $urandom_range(4, 8));
        end
      endcase
    end
    repeat (5) tick(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clock_ratio_monitor.md
# clock_ratio_monitor

Measures a slow clock (typically a `clock_divider` output) in units of the fast reference clock and reports its period, high time and lock status. It is the checking side of clock division: it confirms that a derived clock runs at the expected ratio to `clk_in`. It sits beside each divider instance, on the `clk_in` domain, and feeds status and interrupt logic.

## Interface
- `EXPECTED_DIV`, default 4: expected period of `mon_clk`, counted in `clk_in` cycles; legal values are ≥2.
- `TOL`, default 0: allowed absolute deviation of a measured period from `EXPECTED_DIV`.
- `LOCK_COUNT`, default 4: number of consecutive in-tolerance periods needed before `locked` asserts; legal values are ≥1.
- `CNT_W`, default 16: width of the period and high counters.
- `clk_in  input  1  reference clock`; this is the only clock.
- `rst  input  1  synchronous, active-high reset`
- `enable  input  1  measurement enable`; when low, the block is held idle.
- `mon_clk  input  1  clock under test`; it is treated as asynchronous and sampled on `clk_in`.
- `period_count  output  CNT_W  last measured period, in clk_in cycles`
- `high_count  output  CNT_W  clk_in cycles during which synced mon_clk was high in that period`
- `period_valid  output  1  one-cycle pulse; period_count and high_count updated`
- `locked  output  1  ratio confirmed`
- `mismatch  output  1  one-cycle pulse; completed period out of tolerance`
- `timeout  output  1  one-cycle pulse; no rising edge seen before the counter saturated`

## Operation
- Input path: a 2-flop synchronizer on `mon_clk`, then a delayed copy.
  - `rise` = `sync & ~sync_d`.
  - Rising edges only are used.
- States:
  - IDLE: `enable`=0.
  - ARM: waiting for the first rise.
  - MEASURE: counting.
- Transitions:
  - IDLE→ARM when `enable`=1.
  - ARM→MEASURE on `rise`; nothing is reported for this first edge.
  - MEASURE stays in MEASURE on `rise`, and the completed period is reported.
  - MEASURE→ARM on saturation.
  - Any state →IDLE when `enable`=0.
- Counting:
  - `cnt` loads 1 on the `rise` cycle and increments by 1 every following cycle.
  - On the next `rise`, `cnt` is the period; it reloads 1 in that same cycle.
  - The high counter loads 1 on `rise`; every following cycle it adds 1 when `sync`=1, otherwise holds.
  - Example, DIV=4 with 50% duty: period=4, high=2.
- Saturation:
  - If `cnt` reaches 2^CNT_W−1 without a `rise`: pulse `timeout`, clear `locked` and the match counter, and go to ARM.
  - `period_count` is not updated.
- Match rule: `|period − EXPECTED_DIV| ≤ TOL`, computed at CNT_W+1 bits so there is no wrap.
  - Match: the match counter increments, saturating at LOCK_COUNT. `locked` sets when the counter reaches LOCK_COUNT.
  - Miss: pulse `mismatch`, clear the match counter, clear `locked`.
- `enable` falling: counters and match counter clear and `locked`=0. `period_count` and `high_count` hold their last values.
- Simultaneous events:
  - `rise` and saturation in the same cycle: `rise` wins. The period is reported as 2^CNT_W−1 and `timeout` does not pulse.
  - `rise` in the same cycle `enable` drops: `enable` wins and nothing is reported.

## Timing
- Reset is synchronous. With `rst`=1 at a `clk_in` edge, after that edge:
  - all outputs are 0;
  - state is IDLE;
  - synchronizer flops are 0.
- Reset mid-period discards the partial measurement. After reset, the first `rise` only arms the block.
- Latency: a `mon_clk` rise launched just after `clk_in` edge k produces internal `rise` in the cycle after edge k+2. `period_valid`, `period_count`, `high_count`, `mismatch` and `locked` are all registered and update at edge k+3, together.
- `period_valid` and `mismatch` are never high for more than one cycle. `timeout` and `period_valid` are mutually exclusive.
- Minimum measurable period: 2 `clk_in` cycles. Shorter input pulses may be missed, and that is acceptable.

## Structure
- The shared package `clk_mon_pkg` holds:
  - the `state_t` enum (IDLE, ARM, MEASURE);
  - `localparam SYNC_STAGES = 2`.
- Sub-module `sync_edge_detect`: synchronizer plus the `sync_d` flop. It outputs `sync` and `rise`, and is reused by other clock-domain monitors.
- The top level holds the FSM, the counters, the match logic and the output registers.

## Test plan
- `clock_divider` with DIVIDE_BY=4 drives `mon_clk`, using defaults → `period_valid` once per 4 cycles with `period_count`=4 and `high_count`=2. `locked`=1 at the 4th reported period. `mismatch` never pulses.
- DIVIDE_BY=8 with EXPECTED_DIV=4, TOL=0 → every report has `period_count`=8 and `high_count`=4, `mismatch` pulses each period, `locked` stays 0. Repeat with TOL=4 → `locked` asserts.
- Locked at ratio 4, then the divider switches to 6 → the first 6-period report pulses `mismatch` and drops `locked` in the same cycle. `locked` re-asserts only after the ratio returns to 4 and 4 clean periods complete.
- CNT_W=6, `mon_clk` stopped low after lock → `timeout` pulses once, 63 cycles after the last rise. `locked` goes to 0 and the state returns to ARM. On restart, the first rise gives no report.
- Assert `rst` for 1 cycle mid-period → all outputs 0 the next cycle. The next `period_valid` arrives only after two rises and reports the correct value, 4.
- Drop `enable` in the same cycle as an internal `rise` while locked → no `period_valid`, `locked`=0, `period_count` holds 4.
